// File: rtl/ram_writer_pkg.sv
// ram_writer_pkg: shared defaults and the fill state machine encoding for
// the sequential RAM writer.
package ram_writer_pkg;

  localparam int DEFAULT_DEPTH  = 100;
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_sp_1w1r.sv
// ram_sp_1w1r: DEPTH x WIDTH storage with one synchronous write port and one
// combinational read port. Contents are never reset; the owner is expected
// to clear it explicitly.
module ram_sp_1w1r
  import ram_writer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one word per clock when the write enable is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_writer.sv
// ram_writer: fills a DEPTH-word memory at sequential addresses through a
// valid/ready port, after first zeroing it one word per cycle. Define
// RAM_WRITER_WRAP_EN to make the write address wrap so writing never stops
// (the oldest words are overwritten and full stays high once reached).
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              clear,
  output logic              busy,
  output logic              full,
  output logic [ADDR_W-1:0] count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
`ifdef RAM_WRITER_WRAP_EN
  localparam logic [ADDR_W-1:0] CNT_MAX = ADDR_W'(DEPTH);
`endif

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  assign wr_ready = (state == FILL);
  assign busy     = (state == CLEAR);

  // Steer the single write port: zeroes while clearing, producer data on a
  // handshake; a simultaneous clear drops the handshake.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_addr[IDX_W-1:0];
    mem_wdata = wr_data;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr[IDX_W-1:0];
      mem_wdata = '0;
    end else if (state == FILL && wr_valid && !clear) begin
      mem_we = 1'b1;
    end
  end

  // Clear/fill state machine with its address pointers, count and full flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      wr_addr  <= '0;
      count    <= '0;
      full     <= 1'b0;
    end else if (clear) begin
      state    <= CLEAR;
      clr_addr <= '0;
      wr_addr  <= '0;
      count    <= '0;
      full     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            state    <= FILL;
            clr_addr <= '0;
            wr_addr  <= '0;
            count    <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        FILL: begin
          if (wr_valid) begin
`ifdef RAM_WRITER_WRAP_EN
            wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
            if (count != CNT_MAX) begin
              count <= count + 1'b1;
            end
            if (count == LAST) begin
              full <= 1'b1;
            end
`else
            count <= count + 1'b1;
            if (wr_addr == LAST) begin
              state <= FULL;
              full  <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
`endif
          end
        end
        FULL: begin
          state <= FULL;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  ram_sp_1w1r #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .raddr (rd_addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  assign rd_data = (rd_addr <= LAST) ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: self-checking bench for ram_writer. Accepted writes are
// pushed to a scoreboard queue and later popped and compared against the
// read port; fixed read-back vectors come from a table.
module tb_ram_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        clear = 1'b0;
  logic        busy;
  logic        full;
  logic [7:0]  count;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] data;
  } rd_vec_t;

  sb_t         sb_q[$];
  rd_vec_t     vec[6];
  logic [7:0]  exp_addr = '0;

  ram_writer dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .clear    (clear),
    .busy     (busy),
    .full     (full),
    .count    (count),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic clr);
    wr_valid = valid;
    wr_data  = data;
    clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic writeWord(input logic [31:0] data);
    sb_q.push_back('{addr: exp_addr, data: data});
    exp_addr = exp_addr + 8'd1;
    applyStimulus(1'b1, data, 1'b0);
  endtask

  task automatic readCheck(input string name, input logic [7:0] a,
                           input logic [31:0] expected);
    rd_addr = a;
    #1;
    checkOutput(name, rd_data, expected);
  endtask

  task automatic drainScoreboard(input string name);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      readCheck({name, " sb read"}, e.addr, e.data);
    end
  endtask

  task automatic readAllZero(input string name);
    for (int a = 0; a < 100; a++) begin
      readCheck({name, " zero"}, 8'(a), 32'h0);
    end
  endtask

  task automatic waitClearDone(input string name);
    int cycles = 0;
    bit ready_seen = 1'b0;
    while (busy && cycles < 300) begin
      if (wr_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (wr_ready) ready_seen = ready_seen;
    checkOutput({name, " busy cycles"}, 32'(cycles), 32'd100);
    checkOutput({name, " ready while busy"}, 32'(ready_seen), 32'd0);
    checkOutput({name, " ready after clear"}, 32'(wr_ready), 32'd1);
    checkOutput({name, " count after clear"}, 32'(count), 32'd0);
    checkOutput({name, " full after clear"}, 32'(full), 32'd0);
    exp_addr = '0;
  endtask

  initial begin
    vec[0] = '{name: "rd 5",   addr: 8'd5,   data: 32'h6};
    vec[1] = '{name: "rd 0",   addr: 8'd0,   data: 32'h1};
    vec[2] = '{name: "rd 99",  addr: 8'd99,  data: 32'd100};
    vec[3] = '{name: "rd 120", addr: 8'd120, data: 32'h0};
    vec[4] = '{name: "rd 100", addr: 8'd100, data: 32'h0};
    vec[5] = '{name: "rd 255", addr: 8'd255, data: 32'h0};

    // Reset held low: outputs at their reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd1);
    checkOutput("reset ready", 32'(wr_ready), 32'd0);
    checkOutput("reset full", 32'(full), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    reset = 1'b1;
    waitClearDone("post-reset");
    readAllZero("post-reset");

`ifdef RAM_WRITER_WRAP_EN
    for (int n = 0; n <= 102; n++) begin
      writeWord(32'(n));
      if (n == 99) begin
        checkOutput("wrap full at 100", 32'(full), 32'd1);
        checkOutput("wrap count at 100", 32'(count), 32'd100);
      end
    end
    idle();
    sb_q.delete();
    checkOutput("wrap full", 32'(full), 32'd1);
    checkOutput("wrap count", 32'(count), 32'd100);
    checkOutput("wrap ready", 32'(wr_ready), 32'd1);
    readCheck("wrap rd 0", 8'd0, 32'd100);
    readCheck("wrap rd 1", 8'd1, 32'd101);
    readCheck("wrap rd 2", 8'd2, 32'd102);
    readCheck("wrap rd 3", 8'd3, 32'd3);
    readCheck("wrap rd 120", 8'd120, 32'd0);
`else
    for (int n = 1; n <= 100; n++) begin
      writeWord(32'(n));
      if (n == 99) begin
        checkOutput("count at 99", 32'(count), 32'd99);
        checkOutput("full at 99", 32'(full), 32'd0);
        checkOutput("ready at 99", 32'(wr_ready), 32'd1);
      end
    end
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    idle();
    checkOutput("fill count", 32'(count), 32'd100);
    checkOutput("fill full", 32'(full), 32'd1);
    checkOutput("fill ready", 32'(wr_ready), 32'd0);
    checkOutput("fill busy", 32'(busy), 32'd0);
    drainScoreboard("fill");
    for (int i = 0; i < 6; i++) begin
      readCheck(vec[i].name, vec[i].addr, vec[i].data);
    end
`endif

    // Clear with a simultaneous write, then restart the clear midway.
    applyStimulus(1'b1, 32'hBAD0_0000, 1'b1);
    idle();
    checkOutput("clear busy", 32'(busy), 32'd1);
    checkOutput("clear count", 32'(count), 32'd0);
    checkOutput("clear full", 32'(full), 32'd0);
    repeat (30) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    idle();
    waitClearDone("restart clear");
    readCheck("cleared rd 5", 8'd5, 32'h0);
    readCheck("cleared rd 99", 8'd99, 32'h0);

    // Gapped writes: garbage data on idle cycles must not land anywhere.
    for (int i = 0, n = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        writeWord(32'hA5A5_0000 + 32'(n));
        n++;
      end else begin
        applyStimulus(1'b0, 32'hDEAD_0000 + 32'(i), 1'b0);
      end
    end
    for (int n = 20; n < 40; n++) begin
      writeWord(32'hA5A5_0000 + 32'(n));
    end
    idle();
    checkOutput("gap count", 32'(count), 32'd40);
    drainScoreboard("gap");
    readCheck("gap rd 40", 8'd40, 32'h0);

    // Clear on the 41st word: that word is dropped.
    applyStimulus(1'b1, 32'hBAD1_0000, 1'b1);
    idle();
    checkOutput("drop busy", 32'(busy), 32'd1);
    checkOutput("drop ready", 32'(wr_ready), 32'd0);
    waitClearDone("drop clear");
    readCheck("drop rd 0", 8'd0, 32'h0);
    readCheck("drop rd 40", 8'd40, 32'h0);

    // Reset pulse in the middle of a fill.
    for (int n = 0; n < 50; n++) begin
      writeWord(32'h100 + 32'(n));
    end
    idle();
    checkOutput("pre-reset count", 32'(count), 32'd50);
    drainScoreboard("pre-reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async busy", 32'(busy), 32'd1);
    checkOutput("async ready", 32'(wr_ready), 32'd0);
    checkOutput("async count", 32'(count), 32'd0);
    checkOutput("async full", 32'(full), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    waitClearDone("mid-fill reset");
    readAllZero("mid-fill reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 Parameter DEPTH, default 100, number of 32-bit memory words.
REQ-002 Parameter WIDTH, default 32, data word width.
REQ-003 Parameter ADDR_W, default 8, address and count width.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_valid  input  1  producer presents a word on wr_data.
REQ-007 wr_data  input  WIDTH  word to be stored at the next sequential address.
REQ-008 wr_ready  output  1  block accepts a word this cycle.
REQ-009 clear  input  1  request to zero the memory and restart the fill.
REQ-010 busy  output  1  high while the memory is being cleared.
REQ-011 full  output  1  all DEPTH words have been written since the last clear.
REQ-012 count  output  ADDR_W  number of words written since the last clear, saturating at DEPTH.
REQ-013 rd_addr  input  ADDR_W  read address into the memory.
REQ-014 rd_data  output  WIDTH  combinational read of mem[rd_addr]; 0 when rd_addr >= DEPTH.

Function
REQ-015 The state machine SHALL have states CLEAR, FILL and FULL.
REQ-016 A write SHALL be accepted on a posedge with wr_valid=1 and wr_ready=1; mem[wr_addr] <= wr_data, wr_addr += 1, count += 1.
REQ-017 wr_ready SHALL equal (state==FILL); busy SHALL equal (state==CLEAR); both are combinational from state only.
REQ-018 A written word SHALL be visible on rd_data from the cycle after acceptance (1-cycle write-to-read latency).
REQ-019 In CLEAR, one word per cycle SHALL be zeroed at clr_addr, starting at 0. After the write at DEPTH-1: go to FILL, wr_addr=0, count=0 (exactly DEPTH cycles in CLEAR).
REQ-020 In FILL, the accepted write at wr_addr=DEPTH-1 SHALL move to FULL. full=1 from the next cycle.
REQ-021 In FULL, wr_valid SHALL be ignored; memory, count and wr_addr SHALL hold.
REQ-022 clear=1 in any state SHALL enter CLEAR with clr_addr=0 on the next posedge. clear has priority over a simultaneous handshake, which is dropped. clear during CLEAR restarts from address 0.
REQ-023 full SHALL be 0 in CLEAR and FILL, and in FULL as given in REQ-020.
REQ-024 count SHALL never exceed DEPTH; wr_addr SHALL never exceed DEPTH-1.

Reset
REQ-025 reset=0 SHALL immediately force state=CLEAR, clr_addr=0, wr_addr=0, count=0 and full=0.
REQ-026 Memory contents SHALL NOT be reset directly. The post-reset CLEAR pass guarantees all-zero contents before wr_ready first rises.
REQ-027 reset asserted mid-CLEAR or mid-FILL SHALL restart the full clear sequence after release.

Configuration
REQ-028 Macro RAM_WRITER_WRAP_EN.
- Defined: after the write at DEPTH-1, wr_addr wraps to 0 and state stays FILL (FULL unreachable). count saturates at DEPTH. full asserts when count reaches DEPTH and stays high until clear or reset. Writes continue, overwriting the oldest words.
- Undefined: behaviour per REQ-020/021.

Structure
REQ-029 Package ram_writer_pkg SHALL hold DEPTH/WIDTH/ADDR_W defaults and the state enum (CLEAR, FILL, FULL).
REQ-030 Storage SHALL be a sub-module ram_sp_1w1r: one synchronous write port, one combinational read port, DEPTH x WIDTH, no reset.

Verification
REQ-031 Release reset -> busy=1 and wr_ready=0 for exactly 100 cycles, then wr_ready=1, count=0; all rd_addr 0..99 read 0.
REQ-032 Write 0x1,0x2,... with wr_valid held high (100 words) -> count=100, full=1, wr_ready=0. rd_addr=5 gives 0x6; rd_addr=120 gives 0.
REQ-033 Toggle wr_valid every other cycle with 0xA5A5_0000+n -> only handshake cycles are written; no gaps in addresses.
REQ-034 After 40 writes, assert clear together with wr_valid -> that word is dropped. busy for 100 cycles, then count=0; rd_addr=0 gives 0.
REQ-035 With RAM_WRITER_WRAP_EN defined, write 103 words 0..102 -> full=1, count=100, wr_ready=1; rd_addr=0..2 give 100..102.
REQ-036 Assert reset for 1 cycle at count=50 -> outputs return to reset values at once; a clear pass of 100 cycles follows, then the memory reads all-zero.
